// File: rtl/lpm_ff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lpm_ff_pkg
// Description : Shared constants and width helpers for the lpm_ff_pipe slice.
// Revision    : 1.0 - initial release
// ============================================================================
package lpm_ff_pkg;

    localparam int LPM_FF_MAX_DEPTH = 16;

    function automatic int lpm_ff_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Occupancy must be able to represent DEPTH itself, not only DEPTH-1.
    function automatic int lpm_ff_occ_width(input int depth);
        return (lpm_ff_clog2(depth + 1) < 1) ? 1 : lpm_ff_clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lpm_ff_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : lpm_ff_pipe_if
// Description : Upstream/downstream handshake bundle of lpm_ff_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface lpm_ff_pipe_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    import lpm_ff_pkg::*;

    localparam int OCC_W = lpm_ff_occ_width(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, occupancy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/lpm_ff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : lpm_ff_stage
// Description : One pipeline slice: full flag, data register, ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module lpm_ff_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic             clock,
    input  wire logic             sclr,
    input  wire logic             flush,
    input  wire logic             up_valid,
    input  wire logic [WIDTH-1:0] up_data,
    input  wire logic             dn_rdy,
    output logic                  full,
    output logic [WIDTH-1:0]      data,
    output logic                  rdy
);
    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    // An empty stage takes a word regardless of what lies downstream.
    assign rdy    = !r_full || dn_rdy;
    assign w_load = up_valid && rdy;

    always_ff @(posedge clock) begin
        if (sclr) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_data <= up_data;
        end else if (dn_rdy) begin
            r_full <= 1'b0;
        end
    end

    assign full = r_full;
    assign data = r_data;

endmodule
`default_nettype wire

// File: rtl/lpm_ff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lpm_ff_pipe
// Description : DEPTH-stage valid/ready pipeline register with bubble collapse.
//               Optional flush port enabled by LPM_FF_PIPE_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module lpm_ff_pipe
    import lpm_ff_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  wire logic     clock,
    input  wire logic     sclr,
`ifdef LPM_FF_PIPE_FLUSH_EN
    input  wire logic     flush,
`endif
    lpm_ff_pipe_if.slave  bus
);
    localparam int OCC_W = lpm_ff_occ_width(DEPTH);

    logic [DEPTH-1:0] w_full;
    logic [DEPTH:0]   w_rdy;
    logic [DEPTH-1:0] w_up_valid;
    logic [WIDTH-1:0] w_up_data [DEPTH];
    logic [WIDTH-1:0] w_data    [DEPTH];
    logic [OCC_W-1:0] w_occ;
    logic             w_flush;

`ifdef LPM_FF_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_rdy[DEPTH] = bus.out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_up_valid[k] = bus.in_valid && !sclr && !w_flush;
            assign w_up_data[k]  = bus.in_data;
        end else begin : g_body
            assign w_up_valid[k] = w_full[k-1];
            assign w_up_data[k]  = w_data[k-1];
        end

        lpm_ff_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clock    (clock),
            .sclr     (sclr),
            .flush    (w_flush),
            .up_valid (w_up_valid[k]),
            .up_data  (w_up_data[k]),
            .dn_rdy   (w_rdy[k+1]),
            .full     (w_full[k]),
            .data     (w_data[k]),
            .rdy      (w_rdy[k])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + OCC_W'(w_full[k]);
        end
    end

    assign bus.in_ready  = w_rdy[0] && !sclr && !w_flush;
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.out_valid = w_full[DEPTH-1];
    assign bus.occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_lpm_ff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpm_ff_pipe
// Description : Self-checking bench for lpm_ff_pipe (WIDTH=32, DEPTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpm_ff_pipe;

    localparam int D = 3;

    logic clock;
    logic sclr;
    logic flush;

    lpm_ff_pipe_if #(.WIDTH(32), .DEPTH(D)) bus ();

    lpm_ff_pipe #(
        .WIDTH (32),
        .DEPTH (D)
    ) dut (
        .clock (clock),
        .sclr  (sclr),
`ifdef LPM_FF_PIPE_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        sclr;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        int          e_occ;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        int          pos;
    } ent_t;

    vec_t        tbl [15];
    ent_t        q [$];
    logic [31:0] last_out;
    int          n_vec;
    int          n_err;
    logic [31:0] nxt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: ordered list of words with their stage index. A word advances
    // whenever there is an empty stage anywhere ahead of it or the sink takes.
    task automatic model_update(input logic s, input logic iv, input logic [31:0] d,
                                input logic ordy, input logic fl, output logic acc);
        ent_t nq [$];
        acc = 1'b0;
        if (s) begin
            q.delete();
            last_out = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            acc = iv && ((q.size() < D) || ordy);
            for (int i = 0; i < q.size(); i++) begin
                ent_t e;
                e = q[i];
                if ((i < D - 1 - e.pos) || ordy) begin
                    e.pos = e.pos + 1;
                    if (e.pos == D - 1) last_out = e.d;
                end
                if (e.pos < D) nq.push_back(e);
            end
            if (acc) begin
                nq.push_back('{d, 0});
                if (D == 1) last_out = d;
            end
            q = nq;
        end
    endtask

    task automatic step(input logic s, input logic iv, input logic [31:0] d,
                        input logic ordy, input logic fl, output logic acc);
        logic m_ir;
        logic m_ov;
        sclr          = s;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #3;
        m_ir = !s && !fl && ((q.size() < D) || ordy);
        m_ov = (q.size() > 0) && (q[0].pos == D - 1);
        chk("in_ready",  32'(bus.in_ready),  32'(m_ir));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_data",  bus.out_data,       last_out);
        chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
        model_update(s, iv, d, ordy, fl, acc);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic acc;
        n_vec = 0;
        n_err = 0;
        nxt   = 32'h1;

        //            sclr  iv    data           ordy  ir    ov    od            occ
        tbl[0]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[1]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h0, 0};
        tbl[2]  = '{1'b0, 1'b1, 32'h1,        1'b1, 1'b1, 1'b0, 32'h0, 0};
        tbl[3]  = '{1'b0, 1'b1, 32'h2,        1'b1, 1'b1, 1'b0, 32'h0, 1};
        tbl[4]  = '{1'b0, 1'b1, 32'h3,        1'b1, 1'b1, 1'b0, 32'h0, 2};
        tbl[5]  = '{1'b0, 1'b1, 32'h4,        1'b1, 1'b1, 1'b1, 32'h1, 3};
        tbl[6]  = '{1'b0, 1'b1, 32'h5,        1'b1, 1'b1, 1'b1, 32'h2, 3};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h3, 3};
        tbl[8]  = '{1'b0, 1'b1, 32'h6,        1'b1, 1'b1, 1'b1, 32'h3, 3};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4, 3};
        tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h5, 2};
        tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h6, 1};
        tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h6, 0};
        tbl[13] = '{1'b1, 1'b1, 32'h000000AA, 1'b1, 1'b0, 1'b0, 32'h6, 0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0, 0};

        // Bring the registers out of their power-up state before checking.
        sclr          = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        q.delete();
        last_out = '0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 15; i++) begin
            sclr          = tbl[i].sclr;
            flush         = 1'b0;
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].d;
            bus.out_ready = tbl[i].ordy;
            #3;
            chk("tbl_in_ready",  32'(bus.in_ready),  32'(tbl[i].e_ir));
            chk("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_ov));
            chk("tbl_out_data",  bus.out_data,       tbl[i].e_od);
            chk("tbl_occupancy", 32'(bus.occupancy), 32'(tbl[i].e_occ));
            model_update(tbl[i].sclr, tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0, acc);
            @(posedge clock);
            #1;
        end

        // Streaming 1..16 back-to-back, then drain.
        nxt = 32'h1;
        for (int c = 0; c < 24; c++) begin
            step(1'b0, nxt <= 32'h10, nxt, 1'b1, 1'b0, acc);
            if (acc) nxt++;
        end

        // Stall window on cycles 5..12 while the source keeps offering.
        nxt = 32'h100;
        for (int c = 0; c < 30; c++) begin
            step(1'b0, nxt < 32'h110, nxt, !(c >= 5 && c <= 12), 1'b0, acc);
            if (acc) nxt++;
        end

        // Bubble collapse: valid 1,0,0,1 against a stalled sink, then release.
        step(1'b0, 1'b1, 32'hB0, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 32'hB1, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0,  1'b0, 1'b0, acc);
        chk("bubble_occupancy", 32'(bus.occupancy), 32'd2);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);

`ifdef LPM_FF_PIPE_FLUSH_EN
        for (int c = 0; c < 4; c++) step(1'b0, 1'b1, 32'hF0 + 32'(c), 1'b0, 1'b0, acc);
        step(1'b0, 1'b1, 32'hF00D, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, acc);
`endif

        // Randomised traffic with occasional clears.
        for (int c = 0; c < 2000; c++) begin
            logic s;
            logic fl;
            s  = ($urandom_range(0, 63) == 0);
            fl = 1'b0;
`ifdef LPM_FF_PIPE_FLUSH_EN
            fl = ($urandom_range(0, 31) == 0);
`endif
            step(s, 1'($urandom), $urandom, ($urandom_range(0, 3) != 0), fl, acc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
